// File: rtl/mem_load_pkg.sv
// Shared encodings for the MEM-stage load unit: load opcodes, FSM states,
// data word width and the alignment rule used when LOAD_ALIGN_CHECK_EN is set.
package mem_load_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100
    } load_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_RESP = 2'b10
    } load_state_e;

    // Reserved opcodes behave as LW, so they need a word-aligned address too.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            OP_LH, OP_LHU: mis = addr_lo[0];
            OP_LB, OP_LBU: mis = 1'b0;
            default:       mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte/halfword selection and sign/zero extension of a loaded word.
// Lane 0 is bits [7:0], matching the store-side byte merge convention.
module load_extract
    import mem_load_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [2:0]        op,
    input  logic [1:0]        addr,
    output logic [WORD_W-1:0] result
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word[8*gi +: 8];
        end
    endgenerate

    // Halfword selection only looks at addr[1]; addr[0] is deliberately ignored.
    assign half_sel = addr[1] ? word[31:16] : word[15:0];
    assign byte_sel = lanes[addr];

    always_comb begin
        result = word;
        case (op)
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0000, half_sel};
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h000000, byte_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: one word read per request, extract/extend, hold result for writeback.
// Optional LOAD_ALIGN_CHECK_EN: misaligned LW/LH/LHU skip the read and respond with rsp_err=1.
module mem_load_unit
    import mem_load_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_op,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err
);

    load_state_e       state_reg;
    logic [2:0]        op_reg;
    logic [1:0]        addr_lo_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              req_ready_reg;
    logic              mem_rd_en_reg;
    logic              rsp_valid_reg;
    logic [WORD_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;

    logic              req_accept;
    logic              req_misaligned;
    logic [WORD_W-1:0] extract_word;

    assign req_accept = req_valid && req_ready_reg && (state_reg == ST_IDLE);

`ifdef LOAD_ALIGN_CHECK_EN
    assign req_misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    // Extraction uses the op and low address bits captured at acceptance,
    // so the request inputs are free to change while the read is in flight.
    load_extract u_extract (
        .word   (mem_rd_data),
        .op     (op_reg),
        .addr   (addr_lo_reg),
        .result (extract_word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_LW;
            addr_lo_reg   <= 2'b00;
            mem_addr_reg  <= '0;
            req_ready_reg <= 1'b0;
            mem_rd_en_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_accept) begin
                        op_reg        <= req_op;
                        addr_lo_reg   <= req_addr[1:0];
                        mem_addr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
                        req_ready_reg <= 1'b0;
                        if (req_misaligned) begin
                            // No memory traffic: answer straight from IDLE.
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_data_reg  <= '0;
                            rsp_err_reg   <= 1'b1;
                        end else begin
                            state_reg     <= ST_READ;
                            mem_rd_en_reg <= 1'b1;
                        end
                    end else begin
                        // Also raises req_ready one cycle after reset release.
                        req_ready_reg <= 1'b1;
                    end
                end

                ST_READ: begin
                    if (mem_rd_valid) begin
                        state_reg     <= ST_RESP;
                        mem_rd_en_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= extract_word;
                        rsp_err_reg   <= 1'b0;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    mem_rd_en_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign mem_rd_en = mem_rd_en_reg;
    assign mem_addr  = mem_addr_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Load-side companion to the store-byte merge logic in the MEM stage: accepts a load request (LW/LH/LHU/LB/LBU) from the pipeline, performs one word read from data memory over a valid/valid handshake, and extracts plus sign- or zero-extends the addressed byte or halfword. The result is held in an output register and offered to writeback over a valid/ready handshake. Byte lanes follow the store convention: addr[1:0]=00 selects bits [7:0], 01 selects [15:8], 10 selects [23:16], 11 selects [31:24].

## Interface
- ADDR_W, 32, address width; the memory address is word-aligned.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101–111 reserved and treated as LW.
- mem_rd_en  out  1  word read request; held high throughout READ.
- mem_addr  out  ADDR_W  {req_addr[ADDR_W-1:2], 2'b00}, registered at acceptance.
- mem_rd_valid  in  1  read data valid; sampled only in READ.
- mem_rd_data  in  32  read word.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  extended load result.
- rsp_err  out  1  misalignment flag; only with LOAD_ALIGN_CHECK_EN, otherwise constant 0.

## Operation
- The FSM has three states: IDLE, READ, RESP.
- IDLE → READ on req_valid && req_ready. Capture the op, addr[1:0] and the aligned mem_addr.
- READ: assert mem_rd_en until mem_rd_valid is high. In that cycle, extract and extend mem_rd_data into rsp_data, then move to RESP.
- RESP: hold rsp_valid, rsp_data and rsp_err stable until rsp_ready is high, then return to IDLE.
- Extraction rules:
  - LW: the whole word.
  - LH/LHU: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16]; addr[0] is ignored.
  - LB/LBU: the byte lane selected by addr[1:0].
  - LH/LB sign-extend from the top bit of the selected field; LHU/LBU zero-extend.
- Reset (reset=0 at a rising edge) forces IDLE from any state and abandons any outstanding read.
  - Reset values: req_ready=0 while reset is held, then 1 in IDLE.
  - mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- mem_rd_valid outside READ is ignored. rsp_ready outside RESP is ignored.
- req_valid while not in IDLE is not accepted; the requester must hold it.

## Timing
- Request accepted at edge N: mem_rd_en is high in the cycle after N.
- mem_rd_valid sampled high at edge M: rsp_valid is high in the cycle after M.
- Minimum latency is 2 cycles from acceptance to rsp_valid, with a zero-wait memory.
- Wait states are unbounded; the unit holds READ indefinitely.
- Response handshake completes at edge K (rsp_valid && rsp_ready): req_ready is high in the cycle after K.
- Maximum throughput is one load per 3 cycles; there is no overlap between requests.
- All outputs are registered; none depends combinationally on any input.

## Configuration
- LOAD_ALIGN_CHECK_EN defined:
  - Misaligned requests are LW with addr[1:0]≠00, or LH/LHU with addr[0]=1.
  - A misaligned request goes IDLE → RESP directly: no memory read, mem_rd_en stays 0, rsp_data=0, rsp_err=1.
  - Response timing is 1 cycle after acceptance; the rsp_ready handshake is unchanged.
- LOAD_ALIGN_CHECK_EN undefined:
  - No check is performed; rsp_err is tied to 0.
  - Low address bits are ignored exactly as described in Operation.

## Structure
- Package mem_load_pkg holds:
  - The req_op encodings (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU).
  - The FSM state encoding (ST_IDLE, ST_READ, ST_RESP).
  - The word-width constant.
- Sub-module load_extract is combinational: inputs word, op, and addr[1:0]; output the 32-bit extended value. The top level instantiates it in the READ capture path.
- The FSM and registers live in mem_load_unit.

## Test plan
- LB at addr 0x0000_1003, mem word 0x80FF_7F01, mem_rd_valid on the first READ cycle → rsp_data=0xFFFF_FF80; rsp_valid is 2 cycles after acceptance.
- LBU at addr 0x1001 on the same word → rsp_data=0x0000_007F. LHU at addr 0x1002 → rsp_data=0x0000_80FF. LH at 0x1002 → 0xFFFF_80FF.
- LW at addr 0x2000 with mem_rd_valid delayed 5 cycles → mem_rd_en is held high 6 cycles and mem_addr=0x2000 stays stable throughout. rsp_valid stays high with rsp_ready=0 for 3 cycles; rsp_data is unchanged, and req_ready=0 until the cycle after the handshake.
- Reset driven low while in READ → next cycle: mem_rd_en=0, rsp_valid=0, req_ready=1 after release. A late mem_rd_valid=1 with data 0xDEAD_BEEF is ignored and produces no response.
- With LOAD_ALIGN_CHECK_EN, LW at 0x3002 → mem_rd_en never asserts; rsp_valid=1 with rsp_err=1 and rsp_data=0, 1 cycle after acceptance. Without the macro, the same request reads 0x3000 and rsp_err=0.
- Reserved op 3'b111 at 0x4000 with word 0x1234_5678 → rsp_data=0x1234_5678 (treated as LW).
